// File: rtl/chdr_traffic_checker.sv
// Purpose : CHDR traffic sink/checker for one crossbar egress port; checks size, payload,
//           destination and per-source sequence, and gathers latency/throughput statistics.
// Latency : all statistics, err_stb/err_code/err_src update 1 cycle after the tlast beat.
// Backpr. : none; s_axis_tready is tied high and every beat is consumed at line rate.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   current_time          free-running 64-bit time, same timebase as the traffic source
//   start_stb             single-cycle pulse: clear statistics and (re)start a session
//   lines_per_pkt         expected beats per packet including header and timestamp (>=3)
//   s_axis_*              CHDR input stream (only tdata[63:0] interpreted)
//   session_active        a session is running and packets are being checked
//   xfer_count            sum of lines_per_pkt over checked packets
//   pkt_count             checked packets completed
//   data/route/seq_err_count  packets with size-or-payload / destination / sequence error
//   lat_min, lat_max      latency extremes of this session (saturated to LAT_W)
//   lat_sum               wrapping 48-bit sum of latencies
//   err_stb/err_code/err_src  per-packet error pulse, {seq,dest,data,size} bits, source SID
module chdr_traffic_checker #(
    parameter int          WIDTH        = 64,
    parameter logic [15:0] NODE_ID      = 16'd0,
    parameter int          NUM_NODES    = 16,
    parameter int          IDLE_TO_LOG2 = 13,
    parameter int          CNT_W        = 32,
    parameter int          LAT_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [63:0]       current_time,
    input  logic              start_stb,
    input  logic [15:0]       lines_per_pkt,
    input  logic [WIDTH-1:0]  s_axis_tdata,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic              session_active,
    output logic [CNT_W-1:0]  xfer_count,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  data_err_count,
    output logic [CNT_W-1:0]  route_err_count,
    output logic [CNT_W-1:0]  seq_err_count,
    output logic [LAT_W-1:0]  lat_min,
    output logic [LAT_W-1:0]  lat_max,
    output logic [47:0]       lat_sum,
    output logic              err_stb,
    output logic [3:0]        err_code,
    output logic [15:0]       err_src
);

    localparam logic [1:0] ST_HDR  = 2'd0;
    localparam logic [1:0] ST_TIME = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam int IDX_W = $clog2(NUM_NODES);

    // ------------------------------------------------------------------
    // Beat decode
    // ------------------------------------------------------------------
    logic [63:0] beat_dat;
    logic [11:0] hdr_seq;
    logic [15:0] hdr_src;
    logic [15:0] hdr_dst;
    logic [IDX_W-1:0] hdr_idx;

    assign s_axis_tready = 1'b1;
    assign beat_dat      = s_axis_tdata[63:0];
    assign hdr_seq       = beat_dat[59:48];
    assign hdr_src       = beat_dat[31:16];
    assign hdr_dst       = beat_dat[15:0];
    assign hdr_idx       = hdr_src[IDX_W-1:0];

    // ------------------------------------------------------------------
    // Framing state
    // ------------------------------------------------------------------
    logic [1:0]  state;
    logic [15:0] beat_idx;     // beats already consumed in the current packet
    logic        pkt_chk;      // current packet is being checked
    logic        data_bad;     // payload mismatch seen; later beats no longer compared
    logic        dst_bad;
    logic        seq_bad;
    logic [15:0] src_q;
    logic [63:0] ts_q;

    // Sequence table: valid bits carry the reset so a session start clears it in one cycle
    logic [NUM_NODES-1:0] seq_vld;
    logic [11:0]          seq_mem [NUM_NODES];

    logic [IDLE_TO_LOG2:0] idle_cnt;

    // ------------------------------------------------------------------
    // Per-beat evaluation
    // ------------------------------------------------------------------
    logic        hdr_beat;
    logic        cur_chk;
    logic        seq_hit;
    logic [11:0] seq_exp;
    logic        dst_err_now;
    logic        seq_err_now;
    logic        data_err_now;
    logic        pkt_data_err;
    logic        pkt_dst_err;
    logic        pkt_seq_err;
    logic        pkt_size_err;
    logic [15:0] beat_cnt;
    logic [15:0] beat_idx_inc;
    logic [3:0]  pkt_code;
    logic [15:0] pkt_src;
    logic        pkt_done;

    always_comb begin
        hdr_beat     = (state == ST_HDR);
        // The beat that coincides with start_stb is always dropped; a start in the
        // middle of a packet also drops the remainder of it.
        cur_chk      = hdr_beat ? (session_active && !start_stb) : (pkt_chk && !start_stb);
        seq_hit      = seq_vld[hdr_idx];
        seq_exp      = seq_mem[hdr_idx] + 12'd1;
        dst_err_now  = (hdr_dst != NODE_ID);
        seq_err_now  = seq_hit && (hdr_seq != seq_exp);
        data_err_now = (state == ST_DATA) && !data_bad &&
                       (beat_dat != {48'd0, beat_idx - 16'd2});
        // data_bad is cleared at every tlast, so it is already 0 on a header beat
        pkt_data_err = data_bad || data_err_now;
        pkt_dst_err  = hdr_beat ? dst_err_now : dst_bad;
        pkt_seq_err  = hdr_beat ? seq_err_now : seq_bad;
        beat_idx_inc = (beat_idx == 16'hFFFF) ? beat_idx : beat_idx + 16'd1;
        beat_cnt     = beat_idx_inc;
        pkt_size_err = (beat_cnt != lines_per_pkt);
        pkt_code     = {pkt_seq_err, pkt_dst_err, pkt_data_err, pkt_size_err};
        pkt_src      = hdr_beat ? hdr_src : src_q;
        pkt_done     = s_axis_tvalid && s_axis_tlast && cur_chk;
    end

    // ------------------------------------------------------------------
    // Latency of the completing packet. Packets that end before reaching the
    // payload carry no latched timestamp and do not contribute to latency.
    // ------------------------------------------------------------------
    logic [63:0]      lat_full;
    logic [LAT_W-1:0] lat_sat;
    logic             lat_vld;

    assign lat_full = current_time - ts_q;
    assign lat_vld  = (state == ST_DATA);

    always_comb begin
        lat_sat = lat_full[LAT_W-1:0];
        if ((lat_full >> LAT_W) != 64'd0) begin
            lat_sat = '1;
        end
    end

    // ------------------------------------------------------------------
    // Saturating counter helpers
    // ------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add16(input logic [CNT_W-1:0] v,
                                                   input logic [15:0]      a);
        logic [CNT_W:0] s;
        s = {1'b0, v} + {{(CNT_W-15){1'b0}}, a};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Framing FSM: runs regardless of session state so the stream stays framed
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_HDR;
            beat_idx <= 16'd0;
            pkt_chk  <= 1'b0;
            data_bad <= 1'b0;
            dst_bad  <= 1'b0;
            seq_bad  <= 1'b0;
            src_q    <= 16'd0;
            ts_q     <= 64'd0;
        end else if (s_axis_tvalid) begin
            if (s_axis_tlast) begin
                state    <= ST_HDR;
                beat_idx <= 16'd0;
                data_bad <= 1'b0;
            end else begin
                beat_idx <= beat_idx_inc;
                data_bad <= pkt_data_err;
                case (state)
                    ST_HDR:  state <= ST_TIME;
                    ST_TIME: state <= ST_DATA;
                    default: state <= ST_DATA;
                endcase
            end

            if (hdr_beat) begin
                pkt_chk <= cur_chk;
                src_q   <= hdr_src;
                dst_bad <= dst_err_now;
                seq_bad <= seq_err_now;
            end else if (start_stb) begin
                pkt_chk <= 1'b0;
            end

            if (state == ST_TIME) begin
                ts_q <= beat_dat;
            end
        end
    end

    // Sequence storage has no reset; entries are qualified by seq_vld
    always_ff @(posedge clk) begin
        if (s_axis_tvalid && hdr_beat && cur_chk) begin
            seq_mem[hdr_idx] <= hdr_seq;
        end
    end

    // ------------------------------------------------------------------
    // Session control and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            session_active  <= 1'b0;
            idle_cnt        <= '0;
            seq_vld         <= '0;
            xfer_count      <= '0;
            pkt_count       <= '0;
            data_err_count  <= '0;
            route_err_count <= '0;
            seq_err_count   <= '0;
            lat_min         <= '1;
            lat_max         <= '0;
            lat_sum         <= 48'd0;
            err_stb         <= 1'b0;
            err_code        <= 4'd0;
            err_src         <= 16'd0;
        end else begin
            err_stb <= 1'b0;

            if (start_stb) begin
                session_active  <= 1'b1;
                idle_cnt        <= '0;
                seq_vld         <= '0;
                xfer_count      <= '0;
                pkt_count       <= '0;
                data_err_count  <= '0;
                route_err_count <= '0;
                seq_err_count   <= '0;
                lat_min         <= '1;
                lat_max         <= '0;
                lat_sum         <= 48'd0;
            end else begin
                // Idle timeout only counts at packet boundaries; a stalled packet
                // keeps the session alive indefinitely.
                if (s_axis_tvalid) begin
                    idle_cnt <= '0;
                end else if (hdr_beat && !idle_cnt[IDLE_TO_LOG2]) begin
                    idle_cnt <= idle_cnt + 1'b1;
                    if (idle_cnt[IDLE_TO_LOG2-1:0] == '1) begin
                        session_active <= 1'b0;
                    end
                end

                if (s_axis_tvalid && hdr_beat && cur_chk) begin
                    seq_vld[hdr_idx] <= 1'b1;
                end

                if (pkt_done) begin
                    pkt_count  <= sat_inc(pkt_count);
                    xfer_count <= sat_add16(xfer_count, lines_per_pkt);
                    if (pkt_size_err || pkt_data_err) begin
                        data_err_count <= sat_inc(data_err_count);
                    end
                    if (pkt_dst_err) begin
                        route_err_count <= sat_inc(route_err_count);
                    end
                    if (pkt_seq_err) begin
                        seq_err_count <= sat_inc(seq_err_count);
                    end
                    if (pkt_code != 4'd0) begin
                        err_stb  <= 1'b1;
                        err_code <= pkt_code;
                        err_src  <= pkt_src;
                    end
                    if (lat_vld) begin
                        if (lat_sat < lat_min) begin
                            lat_min <= lat_sat;
                        end
                        if (lat_sat > lat_max) begin
                            lat_max <= lat_sat;
                        end
                        lat_sum <= lat_sum + lat_full[47:0];
                    end
                end
            end
        end
    end

endmodule
